serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial adder/subtractor controller that sequences one existing `add_1bit` full-adder cell over WIDTH cycles to produce an N-bit sum. It is the first multi-bit arithmetic primitive in the crypto datapath. Callers use it when area matters more than latency, such as modular-reduction and counter-mode steps. It owns operand shift registers, the carry flop, the bit counter and the start/done handshake.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits, legal range ≥1.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: request a new operation; sampled only when not busy.
- sub, in, 1: 0 computes a+b+cin; 1 computes a−b as a+~b+1, and cin is ignored.
- a, in, WIDTH: operand A, captured on accepted start.
- b, in, WIDTH: operand B, captured on accepted start.
- cin, in, 1: carry-in for add mode.
- busy, out, 1: high while bits are being processed.
- done, out, 1: one-cycle pulse; sum and cout are valid from this cycle onward.
- sum, out, WIDTH: result register; holds until the next completion.
- cout, out, 1: final carry. In sub mode, 1 means a ≥ b (no borrow).

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE, start=1:**
  - Load sa←a.
  - Load sb←(sub ? ~b : b).
  - Load carry←(sub ? 1 : cin).
  - Set cnt←0 and go to RUN.
- **IDLE, start=0:** stay in IDLE.
- **RUN, each cycle:**
  - The add_1bit inputs are a=sa[0], b=sb[0], c0=carry.
  - Set carry←c1.
  - Shift the s output into the MSB of the partial-sum register ps (right-shift).
  - Right-shift sa and sb.
  - Increment cnt.
- **RUN, cnt==WIDTH−1:** on that edge also copy the completed ps (including the final s) into sum and c1 into cout, then go to DONE.
- **DONE:**
  - done=1 for exactly this cycle.
  - With start=1, the new operands are accepted exactly as in IDLE and the FSM goes directly to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- start is ignored while in RUN. The in-flight operation is unaffected, and no queueing takes place.
- a, b, sub and cin may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH. Overflow is reported only via cout.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0; internal sa, sb, ps, carry and cnt are all 0.
- Reset mid-operation aborts the operation immediately. The outputs return to their reset values on the next edge, and no done pulse is produced.
- Latency:
  - start is accepted at edge k.
  - busy is high during cycles k+1 … k+WIDTH.
  - done is high during cycle k+WIDTH+1.
  - sum and cout change at edge k+WIDTH and are stable through done.
- Throughput is one result per WIDTH+1 cycles with back-to-back start asserted in DONE.
- busy is a registered state decode: (state==RUN). done is (state==DONE). Neither is combinational from start.
- For WIDTH=1, RUN lasts one cycle and completes on the first RUN edge.
- rst and start asserted in the same cycle: rst wins.

## Structure
- **Shared package / header (crypto_arith_pkg):**
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter-width helper CNT_W = $clog2(WIDTH) with minimum 1.
- **Sub-module:** exactly one instance of the existing add_1bit(a,b,c0,s,c1). Do not re-implement the full adder inline.
- **Top level:** FSM, shift registers, carry flop, counter and result registers. Expected size is about 150 lines.

## Test plan
All scenarios use WIDTH=8.
- **Basic add, latency check:** a=0x00, b=0x00, cin=0, sub=0, start pulse → busy for 8 cycles, done in cycle 9 after acceptance, sum=0x00, cout=0.
- **Full carry chain:** a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. With a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0.
- **Subtract:**
  - a=0x5A, b=0x5A, sub=1 → sum=0x00, cout=1.
  - a=0x03, b=0x05, sub=1, cin=1 (ignored) → sum=0xFE, cout=0.
- **Start while busy:** issue a second start with a=0x11, b=0x22 three cycles into a=0x10 + b=0x20 → exactly one done, sum=0x30.
  - Back-to-back: start held high in the DONE cycle with a=0x01, b=0x01 → second done arrives 9 cycles later with sum=0x02.
- **Reset mid-operation:** assert rst for one cycle four cycles after start → busy=0, sum=0, cout=0 next cycle, and no done pulse.
  - A subsequent 0xA5+0x5A → sum=0xFF, cout=0.
- **Boundary, WIDTH=1 instance:** a=1, b=1, cin=1 → done two cycles after acceptance, sum=1, cout=1.

Source files
------------

// File: rtl/crypto_arith_pkg.sv
// crypto_arith_pkg: FSM state encoding and counter-width helper for the bit-serial arithmetic controllers
package crypto_arith_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int width);
    return width > 1 ? $clog2(width) : 1;
  endfunction
endpackage

// File: rtl/add_1bit.sv
// add_1bit: full-adder cell, s = a^b^c0, c1 = carry out
module add_1bit (
  input  logic a,
  input  logic b,
  input  logic c0,
  output logic s,
  output logic c1
);
  assign s = a ^ b ^ c0;
  assign c1 = (a & b) | (c0 & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial a+b+cin / a-b over WIDTH cycles on one add_1bit; start/sub/a/b/cin in, busy/done/sum/cout out
module serial_add_ctrl
  import crypto_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_nxt;
  logic [WIDTH-1:0] sa, sb, ps;
  logic [CW-1:0] cnt;
  logic carry, s, c1, last, load;
  logic [WIDTH:0] ps_ext;
  add_1bit u_add (.a(sa[0]), .b(sb[0]), .c0(carry), .s(s), .c1(c1));
  assign last = cnt == CW'(WIDTH - 1);
  assign ps_ext = {s, ps};
  assign load = start && state != RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_nxt = load ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      ps <= '0;
      cnt <= '0;
      carry <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sa <= a;
        sb <= sub ? ~b : b;
        carry <= sub | cin;
        cnt <= '0;
      end else if (state == RUN) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        ps <= ps_ext[WIDTH:1];
        carry <= c1;
        cnt <= cnt + 1'b1;
        if (last) begin
          sum <= ps_ext[WIDTH:1];
          cout <= c1;
        end
      end
    end
  end
endmodule
